// File: rtl/md_audio_i2s_if.sv
// Audio sample inputs and I2S serial outputs of md_audio_i2s, grouped as one bus.
interface md_audio_i2s_if;
   logic [15:0] A_L;
   logic [15:0] A_R;
   logic        mute;
   logic        I2S_BCLK;
   logic        I2S_LRCK;
   logic        I2S_SDATA;
   logic        sample_stb;

   modport master (
      output A_L, A_R, mute,
      input  I2S_BCLK, I2S_LRCK, I2S_SDATA, sample_stb
   );

   modport slave (
      input  A_L, A_R, mute,
      output I2S_BCLK, I2S_LRCK, I2S_SDATA, sample_stb
   );
endinterface

// File: rtl/md_audio_i2s.sv
// Decimates MCLK-rate stereo samples to one word pair per frame and serializes them as Philips I2S.
// Optional box-filter averaging over the frame is built when AUDIO_AVG_EN is defined.
module md_audio_i2s #(
   parameter int unsigned BCLK_HALF_LOG2 = 3
) (
   input  logic          MCLK,
   input  logic          SRES,
   md_audio_i2s_if.slave bus
);
   localparam int unsigned N  = BCLK_HALF_LOG2 + 7;
   localparam int unsigned DW = 16;
   localparam int unsigned SW = 5;

   logic [N-1:0]  cnt_q, cnt_d;
   logic [DW-1:0] word_l_q, word_l_d, word_r_q, word_r_d;
   logic          bclk_q, bclk_d, lrck_q, lrck_d;
   logic          sdata_q, sdata_d, stb_q, stb_d;
   logic          last_c;
   logic [SW-1:0] slot_c;
   logic [DW-1:0] tx_word_c;
   logic [DW-1:0] new_l_c, new_r_c;

`ifdef AUDIO_AVG_EN
   localparam int unsigned AW = DW + N;

   logic signed [AW-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic signed [AW-1:0] sum_l_c, sum_r_c;

   // Running frame sum; the final cycle's sample is folded in before the floor shift.
   always_comb begin
      sum_l_c = acc_l_q + AW'(signed'(bus.A_L));
      sum_r_c = acc_r_q + AW'(signed'(bus.A_R));
      acc_l_d = last_c ? '0 : sum_l_c;
      acc_r_d = last_c ? '0 : sum_r_c;
      new_l_c = DW'(sum_l_c >>> N);
      new_r_c = DW'(sum_r_c >>> N);
   end

   always_ff @(posedge MCLK or negedge SRES) begin
      if (!SRES) begin
         acc_l_q <= '0;
         acc_r_q <= '0;
      end else begin
         acc_l_q <= acc_l_d;
         acc_r_q <= acc_r_d;
      end
   end
`else
   // Point decimation: the frame's last sample becomes the word.
   always_comb begin
      new_l_c = bus.A_L;
      new_r_c = bus.A_R;
   end
`endif

   // Next-state: clocks and serial data are derived from the next count so every output is a flop.
   always_comb begin
      cnt_d     = cnt_q + N'(1);
      last_c    = (cnt_q == '1);
      bclk_d    = cnt_d[BCLK_HALF_LOG2];
      lrck_d    = cnt_d[N-1];
      stb_d     = last_c;
      slot_c    = cnt_d[N-2:BCLK_HALF_LOG2+1];
      tx_word_c = lrck_d ? word_r_q : word_l_q;
      sdata_d   = 1'b0;
      if ((slot_c >= SW'(1)) && (slot_c <= SW'(16))) begin
         sdata_d = tx_word_c[4'(SW'(16) - slot_c)];
      end
      word_l_d = word_l_q;
      word_r_d = word_r_q;
      if (last_c) begin
         word_l_d = bus.mute ? '0 : new_l_c;
         word_r_d = bus.mute ? '0 : new_r_c;
      end
   end

   always_ff @(posedge MCLK or negedge SRES) begin
      if (!SRES) begin
         cnt_q    <= '0;
         word_l_q <= '0;
         word_r_q <= '0;
         bclk_q   <= 1'b0;
         lrck_q   <= 1'b0;
         sdata_q  <= 1'b0;
         stb_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         word_l_q <= word_l_d;
         word_r_q <= word_r_d;
         bclk_q   <= bclk_d;
         lrck_q   <= lrck_d;
         sdata_q  <= sdata_d;
         stb_q    <= stb_d;
      end
   end

   assign bus.I2S_BCLK   = bclk_q;
   assign bus.I2S_LRCK   = lrck_q;
   assign bus.I2S_SDATA  = sdata_q;
   assign bus.sample_stb = stb_q;
endmodule

// File: tb/tb_md_audio_i2s.sv
// Randomized scoreboard bench for md_audio_i2s: a frame-level reference model queues expected words,
// a monitor decodes the I2S stream and checks timing, padding and words.
module tb_md_audio_i2s;
   localparam int unsigned BH    = 3;
   localparam int unsigned FRAME = 1024;

   logic MCLK = 1'b0;
   logic SRES = 1'b0;

   md_audio_i2s_if bus ();

   md_audio_i2s #(.BCLK_HALF_LOG2(BH)) dut (
      .MCLK (MCLK),
      .SRES (SRES),
      .bus  (bus)
   );

   always #5 MCLK = ~MCLK;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_q[$];
   logic [9:0]  pos;
   longint      sum_l, sum_r;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at t=%0t pos=%0d", name, act, exp, $time, pos);
      end
   endtask

   // Frame position as defined by elapsed edges since reset release.
   always @(posedge MCLK or negedge SRES) begin
      if (!SRES) pos <= '0;
      else       pos <= pos + 10'd1;
   end

   // Reference word for a frame: floor of the mean (averaging build) or the last sample.
   function automatic logic [15:0] expect_word(input longint sum, input logic [15:0] last);
`ifdef AUDIO_AVG_EN
      longint q;
      q = sum / longint'(FRAME);
      if ((sum % longint'(FRAME) != 0) && (sum < 0)) q = q - 1;
      return 16'(q);
`else
      return last;
`endif
   endfunction

   // Monitor: per-cycle clock/strobe checks, padding checks and per-frame word checks.
   logic [15:0] cur_l, cur_r;
   logic [31:0] exp_w;
   logic [4:0]  slot;
   bit          fresh = 1'b1;
   always @(negedge MCLK) begin
      if (!SRES) begin
         check("reset_outputs", {28'd0, bus.I2S_BCLK, bus.I2S_LRCK, bus.I2S_SDATA, bus.sample_stb}, 32'd0);
         cur_l = '0;
         cur_r = '0;
         fresh = 1'b1;
      end else begin
         slot = pos[8:4];
         check("bclk", {31'd0, bus.I2S_BCLK}, {31'd0, pos[BH]});
         check("lrck", {31'd0, bus.I2S_LRCK}, {31'd0, pos[9]});
         check("sample_stb", {31'd0, bus.sample_stb}, {31'd0, (pos == 10'd0) && !fresh});
         if (pos != 10'd0) fresh = 1'b0;
         if (slot >= 5'd1 && slot <= 5'd16) begin
            if (!pos[9]) cur_l[16 - int'(slot)] = bus.I2S_SDATA;
            else         cur_r[16 - int'(slot)] = bus.I2S_SDATA;
         end else begin
            check("sdata_pad", {31'd0, bus.I2S_SDATA}, 32'd0);
         end
         if (pos == 10'd1023) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
               exp_w = exp_q.pop_front();
               check("word_l", {16'd0, cur_l}, {16'd0, exp_w[31:16]});
               check("word_r", {16'd0, cur_r}, {16'd0, exp_w[15:0]});
            end
         end
      end
   end

   // One MCLK cycle of stimulus; the model closes the frame on its last cycle.
   task automatic drive(input logic [15:0] l, input logic [15:0] r, input logic m);
      bus.A_L  = l;
      bus.A_R  = r;
      bus.mute = m;
      sum_l += longint'($signed(l));
      sum_r += longint'($signed(r));
      if (pos == 10'd1023) begin
         exp_q.push_back(m ? 32'd0 : {expect_word(sum_l, l), expect_word(sum_r, r)});
         sum_l = 0;
         sum_r = 0;
      end
      @(posedge MCLK);
      #1;
   endtask

   task automatic do_reset(input int cyc);
      SRES = 1'b0;
      exp_q.delete();
      exp_q.push_back(32'd0);
      sum_l = 0;
      sum_r = 0;
      repeat (cyc) @(posedge MCLK);
      #1;
      SRES = 1'b1;
   endtask

   // Modes: 0 const random, 1 alternating random pair, 2 per-cycle random,
   // 3 full scale, 4 0x8001/0x7FFE, 5 0x0100/0x0300 and -3/-2 alternation.
   task automatic run_frame(input int mode, input logic mute_last, input int ncyc);
      logic [15:0] a, b, c, d, l, r;
      logic        m;
      a = 16'($urandom); b = 16'($urandom);
      c = 16'($urandom); d = 16'($urandom);
      for (int i = 0; i < ncyc; i++) begin
         case (mode)
            0: begin l = a; r = b; end
            1: begin l = pos[0] ? a : c; r = pos[0] ? b : d; end
            2: begin l = 16'($urandom); r = 16'($urandom); end
            3: begin l = 16'h7FFF; r = 16'h8000; end
            4: begin l = 16'h8001; r = 16'h7FFE; end
            default: begin l = pos[0] ? 16'h0300 : 16'h0100; r = pos[0] ? 16'hFFFE : 16'hFFFD; end
         endcase
         m = (pos == 10'd1023) ? mute_last : 1'($urandom);
         drive(l, r, m);
      end
   endtask

   initial begin
      bus.A_L  = '0;
      bus.A_R  = '0;
      bus.mute = 1'b0;
      sum_l = 0;
      sum_r = 0;
      @(posedge MCLK);
      #1;
      do_reset(20);
      run_frame(4, 1'b0, FRAME);
      run_frame(5, 1'b0, FRAME);
      run_frame(3, 1'b0, FRAME);
      run_frame(0, 1'b1, FRAME);
      run_frame(0, 1'b0, FRAME);
      run_frame(1, 1'b0, FRAME);
      run_frame(2, 1'b0, FRAME);
      run_frame(2, 1'b1, FRAME);
      run_frame(1, 1'b0, FRAME);
      run_frame(0, 1'b0, FRAME);
      // Reset in the middle of left slot 10.
      run_frame(2, 1'b0, 165);
      do_reset(7);
      run_frame(4, 1'b0, FRAME);
      run_frame(2, 1'b0, FRAME);
      run_frame(5, 1'b0, FRAME);
      run_frame(0, 1'b0, FRAME);
      check("scoreboard_leftover", 32'(exp_q.size()), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
